// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared helpers for the Hamming stream decoder:
//     is_parity_pos(p) : 1 when 1-based code position p is a parity position
//     data_pos(i)      : 1-based code position carrying data bit i
//     syn_width(w)     : minimum parity-bit count able to cover a w-bit code
//   SECDED_BITS is 1 when HAMMING_SECDED_EN is defined (extra overall-parity
//   bit on the codeword), else 0.
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam int SECDED_BITS = 1;
`else
    localparam int SECDED_BITS = 0;
`endif

    function automatic logic is_parity_pos(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order.
    function automatic int data_pos(input int idx);
        int n;
        n = 0;
        for (int p = 1; p < 4096; p++) begin
            if (!is_parity_pos(p)) begin
                if (n == idx) return p;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic int syn_width(input int code_w);
        for (int m = 1; m < 31; m++) begin
            if (((1 << m) - 1) >= code_w) return m;
        end
        return 31;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome
//   Combinational syndrome generator.
//   i_code : received codeword, position p on i_code[p-1]; with
//            HAMMING_SECDED_EN an extra overall-parity bit at i_code[CODE_W]
//   o_syn  : syndrome, bit j = XOR of all positions whose index has bit j set
//   o_q    : (HAMMING_SECDED_EN only) XOR of every received bit
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int CODE_W      = 11,
    parameter int PARITY_BITS = 4
) (
    input  logic [CODE_W+SECDED_BITS-1:0] i_code,
    output logic [PARITY_BITS-1:0]        o_syn
`ifdef HAMMING_SECDED_EN
    ,
    output logic                          o_q
`endif
);

    always_comb begin
        o_syn = '0;
        for (int j = 0; j < PARITY_BITS; j++) begin
            for (int p = 1; p <= CODE_W; p++) begin
                if (p[j]) o_syn[j] = o_syn[j] ^ i_code[p-1];
            end
        end
    end

`ifdef HAMMING_SECDED_EN
    assign o_q = ^i_code;
`endif

endmodule

// File: rtl/hamming_stream_decoder.sv
// hamming_stream_decoder
//   Two-stage pipelined shortened-Hamming SEC decoder with valid/ready
//   handshaking and saturating error counters.
//   Optional build macro: HAMMING_SECDED_EN (adds overall-parity bit and
//   double-error detection).
//   Ports:
//     clk, rst                  : clock, synchronous active-high reset
//     in_valid/in_ready/code_in : input stream (code_in is CODE_W+1 wide
//                                 under HAMMING_SECDED_EN)
//     out_valid/out_ready       : output stream handshake
//     data_out, syndrome_out    : corrected data and syndrome of the word
//     err_corr, err_uncorr      : per-word error flags (mutually exclusive)
//     corr_cnt, uncorr_cnt      : saturating counts of flagged words
//     cnt_clr                   : zero both counters (beats an increment)
module hamming_stream_decoder
    import hamming_pkg::*;
#(
    parameter int  PARITY_BITS = 4,
    parameter int  CODE_W      = 11,
    parameter int  CNT_W       = 16,
    localparam int DATA_W      = CODE_W - PARITY_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CODE_W+SECDED_BITS-1:0] code_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             data_out,
    output logic [PARITY_BITS-1:0]        syndrome_out,
    output logic                          err_corr,
    output logic                          err_uncorr,
    output logic [CNT_W-1:0]              corr_cnt,
    output logic [CNT_W-1:0]              uncorr_cnt,
    input  logic                          cnt_clr
);

    if (PARITY_BITS < 2 || CODE_W < PARITY_BITS + 1 ||
        PARITY_BITS < syn_width(CODE_W)) begin : g_bad_cfg
        $error("hamming_stream_decoder: CODE_W out of range for PARITY_BITS");
    end

    localparam logic [PARITY_BITS-1:0] CODE_W_S = PARITY_BITS'(CODE_W);

    // r_vld_pipe[1]: stage-1 valid, r_vld_pipe[2]: output valid
    logic [2:1]             r_vld_pipe;
    logic [DATA_W-1:0]      r_s1_data;
    logic [PARITY_BITS-1:0] r_s1_syn;
    logic [DATA_W-1:0]      r_data;
    logic [PARITY_BITS-1:0] r_syn;
    logic                   r_corr;
    logic                   r_uncorr;
    logic [CNT_W-1:0]       r_corr_cnt;
    logic [CNT_W-1:0]       r_uncorr_cnt;

    logic                   w_adv;
    logic                   w_hs;
    logic [PARITY_BITS-1:0] w_syn;
    logic [DATA_W-1:0]      w_in_data;
    logic [DATA_W-1:0]      w_data;
    logic                   w_corr;
    logic                   w_uncorr;

    assign w_adv    = ~r_vld_pipe[2] | out_ready;
    assign w_hs     = r_vld_pipe[2] & out_ready;
    assign in_ready = w_adv;

    // ---------------- stage 1: syndrome + raw data bits ----------------
`ifdef HAMMING_SECDED_EN
    logic w_q;
    logic r_s1_q;

    hamming_syndrome #(.CODE_W(CODE_W), .PARITY_BITS(PARITY_BITS)) u_syn (
        .i_code (code_in),
        .o_syn  (w_syn),
        .o_q    (w_q)
    );
`else
    hamming_syndrome #(.CODE_W(CODE_W), .PARITY_BITS(PARITY_BITS)) u_syn (
        .i_code (code_in),
        .o_syn  (w_syn)
    );
`endif

    // Only data positions are carried forward; parity bits matter only
    // through the syndrome.
    for (genvar i = 0; i < DATA_W; i++) begin : g_in_data
        localparam int POS = data_pos(i);
        assign w_in_data[i] = code_in[POS-1];
    end

    always_ff @(posedge clk) begin
        if (w_adv && in_valid) begin
            r_s1_data <= w_in_data;
            r_s1_syn  <= w_syn;
`ifdef HAMMING_SECDED_EN
            r_s1_q    <= w_q;
`endif
        end
    end

    // ---------------- stage 2: classify and correct -------------------
    always_comb begin
        w_corr   = 1'b0;
        w_uncorr = 1'b0;
`ifdef HAMMING_SECDED_EN
        // Odd overall parity means one error (possibly in the overall bit
        // itself when s=0); even parity with s!=0 means two errors.
        if (r_s1_q) begin
            if (r_s1_syn > CODE_W_S) w_uncorr = 1'b1;
            else                     w_corr   = 1'b1;
        end else if (r_s1_syn != '0) begin
            w_uncorr = 1'b1;
        end
`else
        if (r_s1_syn > CODE_W_S)     w_uncorr = 1'b1;
        else if (r_s1_syn != '0)     w_corr   = 1'b1;
`endif
    end

    // A syndrome pointing at a parity position matches no data bit, so
    // data passes unchanged while err_corr is still reported.
    for (genvar i = 0; i < DATA_W; i++) begin : g_fix
        localparam int POS = data_pos(i);
        assign w_data[i] = r_s1_data[i] ^
                           (w_corr && (r_s1_syn == PARITY_BITS'(POS)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_data     <= '0;
            r_syn      <= '0;
            r_corr     <= 1'b0;
            r_uncorr   <= 1'b0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[1], in_valid};
            if (r_vld_pipe[1]) begin
                r_data   <= w_data;
                r_syn    <= r_s1_syn;
                r_corr   <= w_corr;
                r_uncorr <= w_uncorr;
            end
        end
    end

    // ---------------- saturating statistics ---------------------------
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_hs) begin
            if (r_corr && r_corr_cnt != '1)       r_corr_cnt   <= r_corr_cnt + 1'b1;
            if (r_uncorr && r_uncorr_cnt != '1)   r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign out_valid    = r_vld_pipe[2];
    assign data_out     = r_data;
    assign syndrome_out = r_syn;
    assign err_corr     = r_corr;
    assign err_uncorr   = r_uncorr;
    assign corr_cnt     = r_corr_cnt;
    assign uncorr_cnt   = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// tb_hamming_stream_decoder
//   Randomized scoreboard bench for hamming_stream_decoder (CODE_W=11,
//   PARITY_BITS=4, CNT_W=3 so counter saturation is reached quickly).
//   Follows HAMMING_SECDED_EN for the codeword width and decode rules.
module tb_hamming_stream_decoder;

    localparam int PB    = 4;
    localparam int CW    = 11;
    localparam int DW    = 7;
    localparam int CNT_W = 3;
`ifdef HAMMING_SECDED_EN
    localparam int IW = CW + 1;
`else
    localparam int IW = CW;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [PB-1:0] syn;
        logic          corr;
        logic          uncorr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IW-1:0]    code_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    data_out;
    logic [PB-1:0]    syndrome_out;
    logic             err_corr;
    logic             err_uncorr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;
    logic             cnt_clr = 1'b0;

    hamming_stream_decoder #(.PARITY_BITS(PB), .CODE_W(CW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .code_in      (code_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .syndrome_out (syndrome_out),
        .err_corr     (err_corr),
        .err_uncorr   (err_uncorr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt),
        .cnt_clr      (cnt_clr)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random backpressure
    int   stall_left = 0;
    bit   clr_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder: syndrome as XOR of set positions, then the
    // classification rules applied to the whole word.
    function automatic exp_t model(input logic [IW-1:0] rx);
        exp_t          e;
        int            s;
        int            n;
        logic [CW-1:0] w;
        s = 0;
        for (int p = 1; p <= CW; p++) if (rx[p-1]) s = s ^ p;
        e = '0;
        e.syn = PB'(s);
        w = rx[CW-1:0];
`ifdef HAMMING_SECDED_EN
        if (^rx) begin
            if (s > CW) e.uncorr = 1'b1;
            else begin
                e.corr = 1'b1;
                if (s != 0) w[s-1] = ~w[s-1];
            end
        end else if (s != 0) e.uncorr = 1'b1;
`else
        if (s > CW) e.uncorr = 1'b1;
        else if (s != 0) begin
            e.corr = 1'b1;
            w[s-1] = ~w[s-1];
        end
`endif
        n = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[n] = w[p-1];
                n++;
            end
        end
        return e;
    endfunction

    function automatic logic [IW-1:0] encode(input logic [DW-1:0] d);
        logic [IW-1:0] c;
        int            n;
        int            s;
        c = '0;
        n = 0;
        s = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[n];
                n++;
            end
        end
        for (int p = 1; p <= CW; p++) if (c[p-1]) s = s ^ p;
        for (int j = 0; j < PB; j++) if (s[j]) c[(1 << j) - 1] = 1'b1;
`ifdef HAMMING_SECDED_EN
        c[CW] = ^c[CW-1:0];
`endif
        return c;
    endfunction

    task automatic send(input logic [IW-1:0] c, input exp_t e);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        code_in  = c;
        #1;
        while (!in_ready) begin
            t++;
            if (t > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL send_timeout: in_ready stuck low for %0d cycles", t);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_rand();
        logic [IW-1:0] c;
        int            r;
        c = encode(DW'($urandom));
        r = $urandom_range(0, 99);
        if (r < 10) c = IW'($urandom);
        else if (r < 50) c[$urandom_range(0, IW-1)] ^= 1'b1;
        else if (r < 65) begin
            c[$urandom_range(0, IW-1)] ^= 1'b1;
            c[$urandom_range(0, IW-1)] ^= 1'b1;
        end
        send(c, model(c));
    endtask

    // Output sink: backpressure and counter clears.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            end
            cnt_clr = clr_en && ($urandom_range(0, 39) == 0);
        end
    end

    // Monitor: scoreboard pops, counter model, stall stability.
    initial begin
        exp_t             e;
        exp_t             act;
        exp_t             prev;
        logic             prev_stall;
        logic             rst_last;
        logic [CNT_W-1:0] m_corr;
        logic [CNT_W-1:0] m_uncorr;
        prev_stall = 1'b0;
        rst_last   = 1'b0;
        m_corr     = '0;
        m_uncorr   = '0;
        prev       = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            act = {data_out, syndrome_out, err_corr, err_uncorr};
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            if (rst_last) begin
                chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
                chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
            end
            if (prev_stall && !rst_last) begin
                chk("stall_valid", 32'(out_valid), 32'(1'b1));
                chk("stall_hold", 32'(act), 32'(prev));
            end
            if (rst) begin
                sb.delete();
                m_corr     = '0;
                m_uncorr   = '0;
                prev_stall = 1'b0;
                rst_last   = 1'b1;
                continue;
            end
            rst_last = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got %0h expected no word", act);
                end else begin
                    e = sb.pop_front();
                    chk("word", 32'(act), 32'(e));
                    if (!cnt_clr) begin
                        if (e.corr && m_corr != '1)     m_corr++;
                        if (e.uncorr && m_uncorr != '1) m_uncorr++;
                    end
                end
            end
            if (cnt_clr) begin
                m_corr   = '0;
                m_uncorr = '0;
            end
            prev_stall = out_valid && !out_ready;
            prev       = act;
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Known-answer words.
`ifdef HAMMING_SECDED_EN
        send(12'hFFF, '{data: 7'h7F, syn: 4'd0, corr: 1'b0, uncorr: 1'b0});
        send(12'h000, '{data: 7'h00, syn: 4'd0, corr: 1'b0, uncorr: 1'b0});
        send(12'h7FF, '{data: 7'h7F, syn: 4'd0, corr: 1'b1, uncorr: 1'b0});
        send(12'hFEB, '{data: 7'h7C, syn: 4'd6, corr: 1'b0, uncorr: 1'b1});
        send(12'h010, '{data: 7'h00, syn: 4'd5, corr: 1'b1, uncorr: 1'b0});
`else
        send(11'h7FF, '{data: 7'h7F, syn: 4'd0, corr: 1'b0, uncorr: 1'b0});
        send(11'h000, '{data: 7'h00, syn: 4'd0, corr: 1'b0, uncorr: 1'b0});
        send(11'h010, '{data: 7'h00, syn: 4'd5, corr: 1'b1, uncorr: 1'b0});
        send(11'h6F7, '{data: 7'h6F, syn: 4'd13, corr: 1'b0, uncorr: 1'b1});
        send(11'h7FE, '{data: 7'h7F, syn: 4'd1, corr: 1'b1, uncorr: 1'b0});
`endif
        idle(4);

        // Four words into a 5-cycle output stall.
        stall_left = 5;
        repeat (4) send_rand();
        idle(8);

        // Random traffic with backpressure and counter clears.
        ready_mode = 1;
        clr_en     = 1'b1;
        repeat (1500) send_rand();

        // Reset while words are in flight.
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (200) send_rand();

        // Drain.
        idle(1);
        ready_mode = 0;
        clr_en     = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d words outstanding, expected 0", sb.size());
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
